// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier that borrows an external shared N-bit adder.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips the RUN phase and finishes in one cycle.
module mult_seq_ctrl #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   add_opea,
    output logic [N-1:0]   add_opeb,
    output logic           add_cin,
    input  logic [N-1:0]   add_sal,
    input  logic           add_cout
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   acc_hi_q, acc_hi_d;
    logic [N-1:0]   acc_lo_q, acc_lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;
    logic [2*N-1:0] shifted;
    logic           zero_op;

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    // One shift-add step: the adder's carry becomes the new top bit of the accumulator.
    assign shifted = {add_cout, add_sal, acc_lo_q[N-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        add_opea  = '0;
        add_opeb  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = multiplicand;
                    acc_hi_d = '0;
                    acc_lo_d = multiplier;
                    cnt_d    = '0;
                    if (zero_op) begin
                        product_d = '0;
                        state_d   = DONE;
                    end else begin
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                add_opea = acc_hi_q;
                add_opeb = acc_lo_q[0] ? mcand_q : '0;
                {acc_hi_d, acc_lo_d} = shifted;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    product_d = shifted;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
    assign add_cin = 1'b0;

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand width; legal N >= 2.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled each rising edge.
REQ-005 SHALL have port multiplicand  input  N  unsigned operand A; sampled when start is accepted.
REQ-006 SHALL have port multiplier  input  N  unsigned operand B; sampled when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; product valid.
REQ-009 SHALL have port product  output  2N  A*B result.
REQ-010 SHALL have port add_opea  output  N  operand a to the external shared N-bit adder.
REQ-011 SHALL have port add_opeb  output  N  operand b to the external adder.
REQ-012 SHALL have port add_cin  output  1  carry-in to the external adder; constant 0.
REQ-013 SHALL have port add_sal  input  N  sum from the external adder (combinational).
REQ-014 SHALL have port add_cout  input  1  carry-out from the external adder.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL hold internal registers mcand (N), acc_hi (N), acc_lo (N) and step counter cnt (clog2(N) bits).
REQ-017 IDLE: start=1 at an edge SHALL load mcand=A, acc_hi=0, acc_lo=B, cnt=0 and go to RUN.
REQ-018 RUN: add_opea=acc_hi; add_opeb = acc_lo[0] ? mcand : 0; add_cin=0.
REQ-019 RUN: each edge SHALL update {acc_hi, acc_lo} <= {add_cout, add_sal, acc_lo[N-1:1]} and increment cnt.
REQ-020 RUN SHALL last exactly N cycles; the edge with cnt==N-1 SHALL go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-022 product SHALL equal {acc_hi, acc_lo}, registered and updated only on the DONE entry edge; held stable until the next DONE.
REQ-023 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-024 Latency: start accepted at edge E0, done high in the cycle following edge EN (N+1 edges after E0).
REQ-025 start in RUN or DONE SHALL be ignored; no queuing; operand inputs are don't-care outside IDLE.
REQ-026 Outside RUN: add_opea=0, add_opeb=0, add_cin=0.
REQ-027 Arithmetic SHALL be unsigned and exact for all 2^N x 2^N operand pairs; no overflow is possible in 2N bits.

Reset
REQ-028 rst_n=0 at an edge SHALL force IDLE, busy=0, done=0, product=0, cnt=0, acc_hi=0, acc_lo=0, mcand=0.
REQ-029 Reset mid-RUN or in DONE SHALL abort the operation with no done pulse; product reads 0.
REQ-030 start while rst_n=0 SHALL be ignored; the first acceptable start is at the first edge with rst_n=1.

Configuration
REQ-031 Macro MULT_ZERO_BYPASS_EN: when defined, start in IDLE with A==0 or B==0 SHALL go directly to DONE.
REQ-032 In the bypass case, done SHALL pulse at the edge after E0 with product=0, busy staying 0 and adder ports staying 0.
REQ-033 When MULT_ZERO_BYPASS_EN is undefined, zero operands SHALL take the full N-cycle RUN path and yield product=0.

Verification
REQ-034 N=8, A=13, B=11, start one cycle -> busy for 8 cycles, done pulse at E0+9, product=0x008F.
REQ-035 N=8, A=255, B=255 -> product=0xFE01 (exercises add_cout every step), same latency.
REQ-036 N=8, A=0, B=77 -> with MULT_ZERO_BYPASS_EN, done at E0+1 and product=0; without it, done at E0+9 and product=0.
REQ-037 N=8, A=13, B=11 with start held high through RUN plus new operands 3,3 -> result 0x008F.
REQ-037 (continued) Second operation starts only from IDLE (first IDLE edge) and gives 0x0009.
REQ-038 N=8, rst_n=0 at cycle 4 of RUN -> busy=0, no done pulse, product=0; a fresh start with 2 and 3 gives 0x0006.
REQ-039 N=32, 1000 random unsigned operand pairs with back-to-back starts -> every product matches a 64-bit reference model and latency is 33 edges.
